// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the parametrised Fibonacci LFSR counter.
package lfsr_pkg;

    typedef enum logic {
        LFSR_FWD = 1'b0,
        LFSR_REV = 1'b1
    } lfsr_dir_e;

    function automatic logic parity32(input logic [31:0] v);
        return ^v;
    endfunction

    // Maximal-length feedback masks, bit i = tap on q[i], MSB always set.
    function automatic logic [31:0] max_len_taps(input int width);
        logic [31:0] m;
        case (width)
            3:       m = 32'h0000_0006;
            4:       m = 32'h0000_000C;
            5:       m = 32'h0000_0014;
            6:       m = 32'h0000_0030;
            7:       m = 32'h0000_0060;
            8:       m = 32'h0000_00B8;
            9:       m = 32'h0000_0110;
            10:      m = 32'h0000_0240;
            11:      m = 32'h0000_0500;
            12:      m = 32'h0000_0829;
            13:      m = 32'h0000_100D;
            14:      m = 32'h0000_2015;
            15:      m = 32'h0000_6000;
            16:      m = 32'h0000_D008;
            17:      m = 32'h0001_2000;
            18:      m = 32'h0002_0400;
            19:      m = 32'h0004_0023;
            20:      m = 32'h0009_0000;
            21:      m = 32'h0014_0000;
            22:      m = 32'h0030_0000;
            23:      m = 32'h0042_0000;
            24:      m = 32'h00E1_0000;
            25:      m = 32'h0120_0000;
            26:      m = 32'h0200_0023;
            27:      m = 32'h0400_0013;
            28:      m = 32'h0900_0000;
            29:      m = 32'h1400_0000;
            30:      m = 32'h2000_0029;
            31:      m = 32'h4800_0000;
            32:      m = 32'h8020_0003;
            default: m = 32'h0000_000C;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational forward/reverse successor of a Fibonacci LFSR state.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(max_len_taps(WIDTH))
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dir,
    output logic [WIDTH-1:0] q_next
);

    logic fwd_bit;
    logic rev_bit;

    // Reverse recovers the bit shifted out by undoing the forward parity.
    always_comb begin
        fwd_bit = parity32(32'(q & TAPS));
        rev_bit = q[0] ^ parity32(32'(q[WIDTH-1:1] & TAPS[WIDTH-2:0]));
        if (lfsr_dir_e'(dir) == LFSR_REV)
            q_next = {rev_bit, q[WIDTH-1:1]};
        else
            q_next = {q[WIDTH-2:0], fwd_bit};
    end

endmodule

// File: rtl/lfsr_counter_param.sv
// Parametrised LFSR counter with load, reverse, TC wrap and lockup recovery.
// Optional step position counter enabled by `LFSR_STEP_CNT_EN.
module lfsr_counter_param
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(max_len_taps(WIDTH)),
    parameter logic [WIDTH-1:0] SEED       = WIDTH'(1),
    parameter logic [WIDTH-1:0] TC_VAL     = {1'b1, {(WIDTH-1){1'b0}}},
    parameter bit               WRAP_AT_TC = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] lfsr_out,
    output logic             tc,
    output logic             lock_err
`ifdef LFSR_STEP_CNT_EN
    ,
    output logic [WIDTH-1:0] step_cnt
`endif
);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_step;
    logic             is_zero;
    logic             load_zero;
    logic             wrap_fwd;
    logic             wrap_rev;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .q      (q),
        .dir    (dir),
        .q_next (q_step)
    );

    always_comb begin
        is_zero   = (q == '0);
        load_zero = (load_val == '0);
        wrap_fwd  = WRAP_AT_TC && !dir && (q == TC_VAL) && !is_zero;
        wrap_rev  = WRAP_AT_TC && dir && (q == SEED) && !is_zero;
    end

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            q        <= SEED;
            lock_err <= 1'b0;
        end else if (load) begin
            q        <= load_zero ? SEED : load_val;
            lock_err <= load_zero;
        end else if (en) begin
            lock_err <= is_zero;
            if (is_zero || wrap_fwd)
                q <= SEED;
            else if (wrap_rev)
                q <= TC_VAL;
            else
                q <= q_step;
        end else begin
            lock_err <= 1'b0;
        end
    end

`ifdef LFSR_STEP_CNT_EN
    // Lockup recovery still counts as a step in the chosen direction.
    always_ff @(posedge clk) begin
        if (!reset || clr || load)
            step_cnt <= '0;
        else if (en && wrap_fwd)
            step_cnt <= '0;
        else if (en)
            step_cnt <= dir ? step_cnt - WIDTH'(1) : step_cnt + WIDTH'(1);
    end
`endif

    assign lfsr_out = q;
    assign tc       = (q == TC_VAL);

endmodule

// File: tb/tb_lfsr_counter_param.sv
// Directed bench for lfsr_counter_param; step counter checks under `LFSR_STEP_CNT_EN.
module tb_lfsr_counter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic       a_reset, a_clr, a_en, a_dir, a_load;
    logic [3:0] a_load_val, a_out;
    logic       a_tc, a_lock;
    logic       b_reset, b_clr, b_en, b_dir, b_load;
    logic [3:0] b_load_val, b_out;
    logic       b_tc, b_lock;
    logic        c_reset, c_clr, c_en, c_dir, c_load;
    logic [15:0] c_load_val, c_out;
    logic        c_tc, c_lock;
`ifdef LFSR_STEP_CNT_EN
    logic [3:0]  a_cnt, b_cnt;
    logic [15:0] c_cnt;
`endif

    lfsr_counter_param dut_a (
        .clk(clk), .reset(a_reset), .clr(a_clr), .en(a_en),
        .dir(a_dir), .load(a_load), .load_val(a_load_val),
        .lfsr_out(a_out), .tc(a_tc), .lock_err(a_lock)
`ifdef LFSR_STEP_CNT_EN
        , .step_cnt(a_cnt)
`endif
    );

    lfsr_counter_param #(
        .TC_VAL(4'd9), .WRAP_AT_TC(1'b1)
    ) dut_b (
        .clk(clk), .reset(b_reset), .clr(b_clr), .en(b_en),
        .dir(b_dir), .load(b_load), .load_val(b_load_val),
        .lfsr_out(b_out), .tc(b_tc), .lock_err(b_lock)
`ifdef LFSR_STEP_CNT_EN
        , .step_cnt(b_cnt)
`endif
    );

    lfsr_counter_param #(
        .WIDTH(16), .TAPS(16'hB400), .SEED(16'd1)
    ) dut_c (
        .clk(clk), .reset(c_reset), .clr(c_clr), .en(c_en),
        .dir(c_dir), .load(c_load), .load_val(c_load_val),
        .lfsr_out(c_out), .tc(c_tc), .lock_err(c_lock)
`ifdef LFSR_STEP_CNT_EN
        , .step_cnt(c_cnt)
`endif
    );

    logic [3:0] inv_q, inv_f, inv_r;
    lfsr_next #(.WIDTH(4), .TAPS(4'b1100)) u_f (
        .q(inv_q), .dir(1'b0), .q_next(inv_f));
    lfsr_next #(.WIDTH(4), .TAPS(4'b1100)) u_r (
        .q(inv_f), .dir(1'b1), .q_next(inv_r));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        a_reset = 1'b0;
        tick();
        tick();
        tests++;
        if (a_out !== 4'd1 || a_lock !== 1'b0 || a_tc !== 1'b0) begin
            fails++;
            $display("FAIL reset: out=%0d lock=%b tc=%b want out=1 lock=0 tc=0",
                     a_out, a_lock, a_tc);
        end
        a_reset = 1'b1;
    endtask

    task automatic test_forward();
        logic [3:0] exp [15] = '{2, 4, 9, 3, 6, 13, 10, 5, 11, 7, 15, 14, 12, 8, 1};
        a_en  = 1'b1;
        a_dir = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            tests++;
            if (a_out !== exp[i] || a_tc !== (exp[i] == 4'd8)) begin
                fails++;
                $display("FAIL fwd[%0d]: out=%0d tc=%b want %0d", i, a_out, a_tc, exp[i]);
            end
        end
    endtask

    task automatic test_reverse();
        logic [3:0] exp [4] = '{4, 2, 1, 8};
        tick();
        tick();
        tick();
        tests++;
        if (a_out !== 4'd9) begin
            fails++;
            $display("FAIL rev_start: out=%0d want 9", a_out);
        end
        a_dir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (a_out !== exp[i] || a_tc !== (i == 3)) begin
                fails++;
                $display("FAIL rev[%0d]: out=%0d tc=%b want %0d", i, a_out, a_tc, exp[i]);
            end
        end
    endtask

    task automatic test_hold();
        a_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (a_out !== 4'd8 || a_tc !== 1'b1 || a_lock !== 1'b0) begin
                fails++;
                $display("FAIL hold[%0d]: out=%0d tc=%b lock=%b want 8 1 0",
                         i, a_out, a_tc, a_lock);
            end
        end
    endtask

    task automatic test_load();
        a_load     = 1'b1;
        a_load_val = 4'd0;
        tick();
        tests++;
        if (a_out !== 4'd1 || a_lock !== 1'b1) begin
            fails++;
            $display("FAIL load_zero: out=%0d lock=%b want 1 1", a_out, a_lock);
        end
        a_load = 1'b0;
        tick();
        tests++;
        if (a_out !== 4'd1 || a_lock !== 1'b0) begin
            fails++;
            $display("FAIL lock_pulse: out=%0d lock=%b want 1 0", a_out, a_lock);
        end
        a_load     = 1'b1;
        a_load_val = 4'd6;
        a_en       = 1'b1;
        tick();
        tests++;
        if (a_out !== 4'd6 || a_lock !== 1'b0) begin
            fails++;
            $display("FAIL load6: out=%0d lock=%b want 6 0", a_out, a_lock);
        end
        a_load = 1'b0;
        a_en   = 1'b0;
    endtask

    task automatic test_wrap();
        logic [3:0] exp [4] = '{2, 4, 9, 1};
        b_reset = 1'b0;
        tick();
        b_reset = 1'b1;
        b_en    = 1'b1;
        b_dir   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (b_out !== exp[i] || b_tc !== (exp[i] == 4'd9)) begin
                fails++;
                $display("FAIL wrap[%0d]: out=%0d tc=%b want %0d", i, b_out, b_tc, exp[i]);
            end
        end
        b_dir = 1'b1;
        tick();
        tests++;
        if (b_out !== 4'd9 || b_tc !== 1'b1) begin
            fails++;
            $display("FAIL wrap_rev: out=%0d tc=%b want 9 1", b_out, b_tc);
        end
        tick();
        tests++;
        if (b_out !== 4'd4) begin
            fails++;
            $display("FAIL wrap_rev2: out=%0d want 4", b_out);
        end
        b_en = 1'b0;
    endtask

    task automatic test_priority();
        a_en  = 1'b1;
        a_dir = 1'b0;
        tick();
        tick();
        tests++;
        if (a_out !== 4'd10) begin
            fails++;
            $display("FAIL prio_run: out=%0d want 10", a_out);
        end
        a_reset = 1'b0;
        a_clr   = 1'b1;
        tick();
        tests++;
        if (a_out !== 4'd1 || a_lock !== 1'b0) begin
            fails++;
            $display("FAIL reset_clr: out=%0d lock=%b want 1 0", a_out, a_lock);
        end
        a_reset = 1'b1;
        a_clr   = 1'b0;
        tick();
        tests++;
        if (a_out !== 4'd2) begin
            fails++;
            $display("FAIL after_clr: out=%0d want 2", a_out);
        end
        a_clr      = 1'b1;
        a_load     = 1'b1;
        a_load_val = 4'd5;
        tick();
        tests++;
        if (a_out !== 4'd1) begin
            fails++;
            $display("FAIL clr_load: out=%0d want 1", a_out);
        end
        a_clr = 1'b0;
        tick();
        tests++;
        if (a_out !== 4'd5) begin
            fails++;
            $display("FAIL load_en: out=%0d want 5", a_out);
        end
        a_load = 1'b0;
        a_en   = 1'b0;
    endtask

`ifdef LFSR_STEP_CNT_EN
    task automatic test_step_cnt();
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        tests++;
        if (a_cnt !== 4'd0) begin
            fails++;
            $display("FAIL cnt_clr0: cnt=%0d want 0", a_cnt);
        end
        a_en  = 1'b1;
        a_dir = 1'b0;
        repeat (5) tick();
        a_dir = 1'b1;
        repeat (2) tick();
        tests++;
        if (a_cnt !== 4'd3 || a_out !== 4'd9) begin
            fails++;
            $display("FAIL cnt_5f2r: cnt=%0d out=%0d want 3 9", a_cnt, a_out);
        end
        repeat (4) tick();
        tests++;
        if (a_cnt !== 4'hF || a_out !== 4'd8) begin
            fails++;
            $display("FAIL cnt_neg: cnt=%0d out=%0d want 15 8", a_cnt, a_out);
        end
        a_en  = 1'b0;
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        tests++;
        if (a_cnt !== 4'd0) begin
            fails++;
            $display("FAIL cnt_clr: cnt=%0d want 0", a_cnt);
        end
    endtask
`endif

    task automatic test_inverse();
        for (int i = 1; i < 16; i++) begin
            inv_q = 4'(i);
            #1;
            tests++;
            if (inv_r !== inv_q) begin
                fails++;
                $display("FAIL inverse[%0d]: rev(fwd)=%0d want %0d", i, inv_r, inv_q);
            end
        end
    endtask

    task automatic test_period16();
        int n = 0;
        c_reset = 1'b0;
        tick();
        c_reset = 1'b1;
        c_en    = 1'b1;
        while (n < 70000) begin
            tick();
            n++;
            if (c_out == 16'd1) break;
        end
        c_en = 1'b0;
        tests++;
        if (n !== 65535) begin
            fails++;
            $display("FAIL period16: steps=%0d want 65535", n);
        end
    endtask

    initial begin
        a_reset = 1'b0; a_clr = 1'b0; a_en = 1'b0; a_dir = 1'b0;
        a_load = 1'b0; a_load_val = 4'd0;
        b_reset = 1'b0; b_clr = 1'b0; b_en = 1'b0; b_dir = 1'b0;
        b_load = 1'b0; b_load_val = 4'd0;
        c_reset = 1'b0; c_clr = 1'b0; c_en = 1'b0; c_dir = 1'b0;
        c_load = 1'b0; c_load_val = 16'd0;
        inv_q = 4'd1;
        test_reset();
        test_forward();
        test_reverse();
        test_hold();
        test_load();
        test_wrap();
        test_priority();
`ifdef LFSR_STEP_CNT_EN
        test_step_cnt();
`endif
        test_inverse();
        test_period16();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
